// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: read-side master for a single-clock FIFO.
// Issues fifo_r_req, captures fifo_r_data and presents words on a valid/ready
// stream through a 2-entry in-order buffer (buf0 is the head).
// FWFT_MODE "TRUE" captures data at the request edge; "FALSE" captures one
// clk later. Optional statistics counters are built when
// FIFO_STREAM_READER_STATS_EN is defined; otherwise they read as zero.
module fifo_stream_reader #(
  parameter string       FWFT_MODE = "TRUE",
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned CNT_W     = 32
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              en,
  input  logic              flush,
  input  logic              fifo_empty,
  output logic              fifo_r_req,
  input  logic [DATA_W-1:0] fifo_r_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  xfer_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam bit FWFT = (FWFT_MODE == "TRUE");

  // Buffer occupancy is the machine state
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic              inflight, inflight_nxt;
  logic [DATA_W-1:0] buf0, buf1, buf0_nxt, buf1_nxt;
  logic [1:0]        occ;
  logic [1:0]        slot;
  logic [2:0]        level;
  logic              pop;
  logic              push;

  assign occ   = state;
  assign pop   = out_valid & out_ready;
  // Pending words after this edge's pop; pop implies occ >= 1, so no underflow
  assign level = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign slot  = occ - {1'b0, pop};

  // Request only when the buffer can absorb the word, never while empty or held in reset
  assign fifo_r_req = nrst & en & ~flush & ~fifo_empty & (level < 3'd2);

  // FWFT data is valid alongside the request; otherwise it arrives one clk later
  assign push = FWFT ? fifo_r_req : inflight;

  assign out_data = buf0;

  // Next-state computation: flush overrides push and pop
  always_comb begin
    state_nxt    = state;
    inflight_nxt = FWFT ? 1'b0 : fifo_r_req;
    buf0_nxt     = buf0;
    buf1_nxt     = buf1;
    if (flush) begin
      state_nxt    = EMPTY;
      inflight_nxt = 1'b0;
      buf0_nxt     = '0;
      buf1_nxt     = '0;
    end else begin
      if (pop) begin
        buf0_nxt = buf1;
      end
      // Write lands at the slot left after this edge's pop shift
      if (push) begin
        if (slot == 2'd0) begin
          buf0_nxt = fifo_r_data;
        end else begin
          buf1_nxt = fifo_r_data;
        end
      end
      case ({push, pop})
        2'b10:   state_nxt = (state == EMPTY) ? ONE : FULL;
        2'b01:   state_nxt = (state == FULL) ? ONE : EMPTY;
        default: state_nxt = state;
      endcase
    end
  end

  // State, buffer and registered stream outputs
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= EMPTY;
      inflight  <= 1'b0;
      buf0      <= '0;
      buf1      <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      inflight  <= inflight_nxt;
      buf0      <= buf0_nxt;
      buf1      <= buf1_nxt;
      out_valid <= (state_nxt != EMPTY);
      busy      <= (state_nxt != EMPTY) | inflight_nxt;
    end
  end

`ifdef FIFO_STREAM_READER_STATS_EN
  // Delivered-word and back-pressure counters; survive flush, wrap naturally
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      xfer_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (pop) begin
        xfer_cnt <= xfer_cnt + CNT_W'(1);
      end
      if (out_valid & ~out_ready) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign xfer_cnt  = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Testbench for fifo_stream_reader: one normal-mode and one FWFT instance,
// each fed by a behavioural FIFO. Stimulus pushes expected words into a
// per-instance queue; a monitor pops and compares on every transfer.
module tb_fifo_stream_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic nrst;

  // Normal-mode instance signals
  logic        en_n, flush_n, rreq_n, valid_n, ready_n, busy_n;
  logic        empty_n = 1'b1;
  logic [31:0] rdata_n = '0;
  logic [31:0] data_n;
  logic [15:0] xfer_n, stall_n;

  // FWFT instance signals
  logic        en_f, flush_f, rreq_f, valid_f, ready_f, busy_f;
  logic        empty_f = 1'b1;
  logic [31:0] rdata_f = '0;
  logic [31:0] data_f;
  logic [15:0] xfer_f, stall_f;

  int tests = 0;
  int fails = 0;
  int viol_empty = 0;
  int viol_hold = 0;

  logic [31:0] fq_n[$], pend_n[$], exp_n[$];
  logic [31:0] fq_f[$], pend_f[$], exp_f[$];

  fifo_stream_reader #(.FWFT_MODE("FALSE"), .DATA_W(32), .CNT_W(16)) dut_n (
    .clk(clk), .nrst(nrst), .en(en_n), .flush(flush_n), .fifo_empty(empty_n),
    .fifo_r_req(rreq_n), .fifo_r_data(rdata_n), .out_valid(valid_n),
    .out_data(data_n), .out_ready(ready_n), .busy(busy_n),
    .xfer_cnt(xfer_n), .stall_cnt(stall_n)
  );

  fifo_stream_reader #(.FWFT_MODE("TRUE"), .DATA_W(32), .CNT_W(16)) dut_f (
    .clk(clk), .nrst(nrst), .en(en_f), .flush(flush_f), .fifo_empty(empty_f),
    .fifo_r_req(rreq_f), .fifo_r_data(rdata_f), .out_valid(valid_f),
    .out_data(data_f), .out_ready(ready_f), .busy(busy_f),
    .xfer_cnt(xfer_f), .stall_cnt(stall_f)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Normal FIFO model: data appears one clk after the request
  always @(posedge clk) begin : fifo_model_n
    logic [31:0] v;
    if (rreq_n && fq_n.size() > 0) begin
      v = fq_n.pop_front();
      rdata_n <= v;
    end
    while (pend_n.size() > 0) fq_n.push_back(pend_n.pop_front());
    empty_n <= (fq_n.size() == 0);
  end

  // FWFT FIFO model: head word always visible on read data
  always @(posedge clk) begin : fifo_model_f
    logic [31:0] v;
    if (rreq_f && fq_f.size() > 0) v = fq_f.pop_front();
    while (pend_f.size() > 0) fq_f.push_back(pend_f.pop_front());
    empty_f <= (fq_f.size() == 0);
    rdata_f <= (fq_f.size() > 0) ? fq_f[0] : '0;
  end

  // Monitors: in-order scoreboard, hold rule, no request while empty
  logic        hold_n = 1'b0, hold_f = 1'b0;
  logic [31:0] held_n = '0, held_f = '0;

  always @(negedge clk) begin : mon_n
    if (nrst) begin
      if (rreq_n && empty_n) viol_empty++;
      if (hold_n && (!valid_n || data_n !== held_n)) viol_hold++;
      if (valid_n && ready_n) begin
        if (exp_n.size() == 0) begin
          tests++; fails++;
          $display("FAIL pop_n: got unexpected word %0h expected none", data_n);
        end else check("pop_n", data_n, exp_n.pop_front());
      end
      hold_n = valid_n & ~ready_n;
      held_n = data_n;
    end else hold_n = 1'b0;
  end

  always @(negedge clk) begin : mon_f
    if (nrst) begin
      if (rreq_f && empty_f) viol_empty++;
      if (hold_f && (!valid_f || data_f !== held_f)) viol_hold++;
      if (valid_f && ready_f) begin
        if (exp_f.size() == 0) begin
          tests++; fails++;
          $display("FAIL pop_f: got unexpected word %0h expected none", data_f);
        end else check("pop_f", data_f, exp_f.pop_front());
      end
      hold_f = valid_f & ~ready_f;
      held_f = data_f;
    end else hold_f = 1'b0;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_n(input logic [31:0] w, input bit expected);
    pend_n.push_back(w);
    if (expected) exp_n.push_back(w);
  endtask

  task automatic load_f(input logic [31:0] w);
    pend_f.push_back(w);
    exp_f.push_back(w);
  endtask

  task automatic drain_n(input string name);
    int k = 0;
    while (exp_n.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check(name, exp_n.size(), 0);
    cyc();
  endtask

  task automatic drain_f(input string name);
    int k = 0;
    while (exp_f.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check(name, exp_f.size(), 0);
    cyc();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [63:0] exp_stall, exp_xfer;
    int after;
    nrst = 1'b0;
    en_n = 1'b0; flush_n = 1'b0; ready_n = 1'b1;
    en_f = 1'b0; flush_f = 1'b0; ready_f = 1'b1;

    // Reset state
    #3;
    check("rst_valid_n", valid_n, 0);
    check("rst_data_n", data_n, 0);
    check("rst_busy_n", busy_n, 0);
    check("rst_req_n", rreq_n, 0);
    check("rst_cnt_n", {xfer_n, stall_n}, 0);
    check("rst_valid_f", valid_f, 0);
    check("rst_busy_f", busy_f, 0);
    cyc(); cyc();
    nrst = 1'b1;

    // 1: normal mode, 2-clk latency then 1 word/clk
    load_n(32'h11, 1); load_n(32'h22, 1); load_n(32'h33, 1);
    cyc(); cyc();
    en_n = 1'b1;
    @(negedge clk); check("t1_req", rreq_n, 1);
    cyc(); @(negedge clk); check("t1_lat_valid", valid_n, 0);
    cyc(); @(negedge clk); check("t1_first_valid", valid_n, 1); check("t1_first_data", data_n, 32'h11);
    cyc(); @(negedge clk); check("t1_rate2", valid_n, 1);
    cyc(); @(negedge clk); check("t1_rate3", valid_n, 1);
    drain_n("t1_drain");
    en_n = 1'b0;

    // 2: FWFT, out_ready alternating 1,0 over 17 clks
    for (int i = 0; i < 8; i++) load_f(32'hA0 + 32'(i));
    cyc(); cyc();
    en_f = 1'b1;
    for (int k = 0; k < 17; k++) begin
      ready_f = (k % 2 == 0);
      cyc();
    end
    ready_f = 1'b1;
    drain_f("t2_drain");
    en_f = 1'b0;
`ifdef FIFO_STREAM_READER_STATS_EN
    exp_stall = 64'd8; exp_xfer = 64'd8;
`else
    exp_stall = 64'd0; exp_xfer = 64'd0;
`endif
    check("t2_stall_cnt", stall_f, exp_stall);
    check("t2_xfer_cnt", xfer_f, exp_xfer);

    // 3: back-pressure with 5 words queued
    ready_n = 1'b0;
    for (int i = 0; i < 5; i++) load_n(32'h51 + 32'(i), 1);
    cyc(); cyc();
    en_n = 1'b1;
    repeat (6) cyc();
    @(negedge clk);
    check("t3_req_low", rreq_n, 0);
    check("t3_fifo_cnt", fq_n.size(), 3);
    check("t3_valid", valid_n, 1);
    check("t3_head", data_n, 32'h51);
    cyc();
    ready_n = 1'b1;
    drain_n("t3_drain");
    en_n = 1'b0;

    // 4: flush the clk after a normal-mode request
    load_n(32'h61, 0); load_n(32'h62, 1); load_n(32'h63, 1);
    cyc(); cyc();
    en_n = 1'b1;
    @(negedge clk); check("t4_req", rreq_n, 1);
    cyc(); flush_n = 1'b1;
    @(negedge clk); check("t4_req_flush", rreq_n, 0);
    cyc(); flush_n = 1'b0;
    @(negedge clk); check("t4_valid", valid_n, 0); check("t4_busy", busy_n, 0);
    drain_n("t4_drain");
    en_n = 1'b0;

    // 6: en low for 4 clks mid-stream, then full-rate resume
    for (int i = 0; i < 8; i++) load_n(32'h71 + 32'(i), 1);
    cyc(); cyc();
    en_n = 1'b1;
    cyc(); cyc(); cyc();
    en_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); check("t6_no_req", rreq_n, 0);
      if (k < 3) cyc();
    end
    check("t6_drained_valid", valid_n, 0);
    check("t6_drained_busy", busy_n, 0);
    cyc(); en_n = 1'b1;
    cyc();
    for (int k = 0; k < 5; k++) begin
      cyc(); @(negedge clk); check("t6_rate", valid_n, 1);
    end
    drain_n("t6_drain");
    en_n = 1'b0;

    // 5: asynchronous reset mid-stream
    for (int i = 0; i < 6; i++) load_n(32'h81 + 32'(i), 1);
    cyc(); cyc();
    en_n = 1'b1;
    cyc(); cyc();
    #2;
    nrst = 1'b0;
    exp_n = fq_n;
    after = fq_n.size();
    #1;
    check("t5_valid", valid_n, 0);
    check("t5_busy", busy_n, 0);
    check("t5_cnt", {xfer_n, stall_n}, 0);
    check("t5_req", rreq_n, 0);
    @(posedge clk); #3;
    nrst = 1'b1;
    drain_n("t5_drain");
    en_n = 1'b0;
`ifdef FIFO_STREAM_READER_STATS_EN
    exp_xfer = 64'(after);
`else
    exp_xfer = 64'd0;
`endif
    check("t5_xfer_cnt", xfer_n, exp_xfer);
    check("t5_stall_cnt", stall_n, 0);

    check("no_req_when_empty", viol_empty, 0);
    check("hold_rule", viol_hold, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
